// File: rtl/seven_segment_reader_if.sv
// Bundle between a multiplexed seven-segment scan source and the reader.
//   segments      : segment pattern for the digit strobed this cycle (bit i = segment i)
//   digit_select  : one-hot digit strobe
//   value         : assembled 4-digit hex value being offered
//   value_valid   : value holds an offer
//   value_ready   : consumer accepts the offer
//   error         : one-cycle pulse for an undecodable pattern or a multi-hot strobe
// master drives the scan and consumes the value; slave is the reader.
interface seven_segment_reader_if;
  logic [6:0]  segments;
  logic [3:0]  digit_select;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        error;

  modport master (
    output segments, digit_select, value_ready,
    input  value, value_valid, error
  );

  modport slave (
    input  segments, digit_select, value_ready,
    output value, value_valid, error
  );
endinterface

// File: rtl/seven_segment_reader.sv
// Reads a scanned 4-digit seven-segment display back into a 16-bit hex value.
// Each digit must show the same pattern for STABLE_COUNT consecutive scans
// before it is decoded; once all four digits hold decoded nibbles and the
// assembled value differs from the last one delivered, it is offered on a
// valid/ready handshake and held stable until taken.
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : scan inputs, value handshake and error pulse (slave side)
//
// Offer state:
//   state   | meaning
//   S_IDLE  | no offer outstanding; value_valid low
//   S_OFFER | value holds an offer; waiting for value_ready
module seven_segment_reader #(
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seven_segment_reader_if.slave bus
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_COUNT);

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [6:0]  pat_q [4];
  logic [6:0]  pat_d [4];
  logic [3:0]  cnt_q [4];
  logic [3:0]  cnt_d [4];
  logic [3:0]  nib_q [4];
  logic [3:0]  nib_d [4];
  logic [3:0]  ok_q, ok_d;
  logic        err_q, err_d;
  logic        delivered_q, delivered_d;
  logic [15:0] last_q, last_d;
  logic [15:0] value_q, value_d;

  logic [15:0] assembled;
  logic        onehot;
  logic        accept;
  logic [4:0]  dec;
  logic        offer_cond;

  // Returns {valid, nibble}; valid = 0 for any pattern outside the glyph set.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1110111: decode = 5'h10;
      7'b0100100: decode = 5'h11;
      7'b1011101: decode = 5'h12;
      7'b1101101: decode = 5'h13;
      7'b0101110: decode = 5'h14;
      7'b1101011: decode = 5'h15;
      7'b1111011: decode = 5'h16;
      7'b0100101: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1101111: decode = 5'h19;
      7'b0111111: decode = 5'h1A;
      7'b1111010: decode = 5'h1B;
      7'b1010011: decode = 5'h1C;
      7'b1111100: decode = 5'h1D;
      7'b1011011: decode = 5'h1E;
      7'b0011011: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    nib_d       = nib_q;
    ok_d        = ok_q;
    delivered_d = delivered_q;
    last_d      = last_q;
    value_d     = value_q;
    accept      = 1'b0;
    dec         = 5'h00;

    assembled = {nib_q[3], nib_q[2], nib_q[1], nib_q[0]};
    onehot    = (bus.digit_select != 4'd0) &&
                ((bus.digit_select & (bus.digit_select - 4'd1)) == 4'd0);
    err_d     = (bus.digit_select != 4'd0) && !onehot;

    if (onehot) begin
      for (int d = 0; d < 4; d++) begin
        if (bus.digit_select[d]) begin
          if (bus.segments == pat_q[d]) begin
            // Once saturated, repeats neither re-decode nor re-flag errors.
            if (cnt_q[d] < STABLE_CNT) begin
              cnt_d[d] = cnt_q[d] + 4'd1;
              accept   = (cnt_q[d] + 4'd1 == STABLE_CNT);
            end
          end else begin
            pat_d[d] = bus.segments;
            cnt_d[d] = 4'd1;
            accept   = (STABLE_CNT == 4'd1);
          end
          if (accept) begin
            dec = decode(bus.segments);
            if (dec[4]) begin
              nib_d[d] = dec[3:0];
              ok_d[d]  = 1'b1;
            end else begin
              ok_d[d]  = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
      end
    end

    offer_cond = (&ok_q) && (!delivered_q || (assembled != last_q));

    case (state_q)
      S_IDLE: begin
        if (offer_cond) begin
          value_d = assembled;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        // Going back through S_IDLE guarantees a low cycle between offers.
        if (bus.value_ready) begin
          last_d      = value_q;
          delivered_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      for (int d = 0; d < 4; d++) begin
        pat_q[d] <= 7'd0;
        cnt_q[d] <= 4'd0;
        nib_q[d] <= 4'd0;
      end
      ok_q        <= 4'd0;
      err_q       <= 1'b0;
      delivered_q <= 1'b0;
      last_q      <= 16'd0;
      value_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      nib_q       <= nib_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      delivered_q <= delivered_d;
      last_q      <= last_d;
      value_q     <= value_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = (state_q == S_OFFER);
  assign bus.error       = err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
module tb_seven_segment_reader;

  localparam int SC = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_reader_if bus ();

  seven_segment_reader #(.STABLE_COUNT(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Glyph table: index = hex digit shown.
  logic [6:0] pat_tab [16] = '{
    7'b1110111, 7'b0100100, 7'b1011101, 7'b1101101,
    7'b0101110, 7'b1101011, 7'b1111011, 7'b0100101,
    7'b1111111, 7'b1101111, 7'b0111111, 7'b1111010,
    7'b1010011, 7'b1111100, 7'b1011011, 7'b0011011
  };

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  logic rdy_g = 1'b1;
  logic [15:0] xfers [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pat [4];
  int m_cnt [4];
  int m_nib [4];
  bit m_ok  [4];
  bit m_deliv, m_vld, m_err;
  int m_last, m_val;

  function automatic int lookup(input int seg);
    for (int i = 0; i < 16; i++)
      if (int'(pat_tab[i]) == seg) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 4; d++) begin
      m_pat[d] = 0; m_cnt[d] = 0; m_nib[d] = 0; m_ok[d] = 0;
    end
    m_deliv = 0; m_vld = 0; m_err = 0; m_last = 0; m_val = 0;
  endtask

  task automatic m_step();
    int value_now, sel, seg, ones, d, k;
    bit all_ok, accept;
    sel = int'(bus.digit_select);
    seg = int'(bus.segments);
    value_now = 0;
    all_ok = 1;
    for (int i = 0; i < 4; i++) begin
      value_now += m_nib[i] * (16 ** i);
      all_ok &= m_ok[i];
    end
    // Handshake decisions are based on the state before this edge.
    if (m_vld) begin
      if (bus.value_ready) begin
        m_last = m_val; m_deliv = 1; m_vld = 0;
      end
    end else if (all_ok && (!m_deliv || value_now != m_last)) begin
      m_val = value_now; m_vld = 1;
    end
    m_err = 0;
    ones = $countones(bus.digit_select);
    if (ones > 1) m_err = 1;
    else if (ones == 1) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (sel == (1 << i)) d = i;
      accept = 0;
      if (seg == m_pat[d]) begin
        if (m_cnt[d] < SC) begin
          m_cnt[d]++;
          accept = (m_cnt[d] == SC);
        end
      end else begin
        m_pat[d] = seg; m_cnt[d] = 1; accept = (SC == 1);
      end
      if (accept) begin
        k = lookup(seg);
        if (k >= 0) begin m_nib[d] = k; m_ok[d] = 1; end
        else begin m_ok[d] = 0; m_err = 1; end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; applies one cycle of inputs and checks at the next falling edge.
  task automatic cyc(input logic [3:0] sel, input logic [6:0] seg, input logic rdy);
    bus.digit_select = sel;
    bus.segments     = seg;
    bus.value_ready  = rdy;
    if (bus.value_valid && rdy) xfers.push_back(bus.value);
    @(posedge clk);
    @(negedge clk);
    chk("valid", {31'd0, bus.value_valid}, {31'd0, m_vld});
    chk("error", {31'd0, bus.error}, {31'd0, m_err});
    if (m_vld) chk("value", {16'd0, bus.value}, m_val);
    if (bus.error) err_seen++;
  endtask

  task automatic scan_one(input int d, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) cyc(4'(1 << d), seg, rdy_g);
  endtask

  task automatic scan_all(input int h0, input int h1, input int h2, input int h3, input int rounds);
    int h [4];
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
    for (int r = 0; r < rounds; r++)
      for (int d = 0; d < 4; d++) cyc(4'(1 << d), pat_tab[h[d]], rdy_g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 7'($urandom), rdy_g);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_value"}, {16'd0, bus.value}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.value_valid}, 32'd0);
    chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int n0, e0;
  int tgt [4];
  logic [3:0] s;

  initial begin
    m_reset();
    bus.digit_select = 4'd0;
    bus.segments     = 7'd0;
    bus.value_ready  = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Four digits stable -> exactly one transfer of 4321, no errors.
    rdy_g = 1'b1;
    n0 = xfers.size(); e0 = err_seen;
    scan_all(1, 2, 3, 4, 3);
    idle(4);
    chk("first_xfer_count", xfers.size() - n0, 1);
    chk("first_xfer_value", {16'd0, xfers[$]}, 32'h4321);
    chk("first_no_error", err_seen - e0, 0);

    // Flickering digit never stabilises; then a stable 8 gives 4328.
    n0 = xfers.size();
    for (int i = 0; i < 3; i++) begin
      scan_one(0, pat_tab[8], 1);
      scan_one(0, pat_tab[9], 1);
    end
    idle(3);
    chk("flicker_no_offer", xfers.size() - n0, 0);
    scan_one(0, pat_tab[8], 3);
    idle(4);
    chk("settle_xfer_count", xfers.size() - n0, 1);
    chk("settle_xfer_value", {16'd0, xfers[$]}, 32'h4328);

    // Undecodable pattern on digit 2: one error, no offer until a valid glyph settles.
    n0 = xfers.size(); e0 = err_seen;
    scan_one(2, 7'b0000001, 3);
    scan_one(2, 7'b0000001, 2);
    idle(3);
    chk("bad_pat_one_error", err_seen - e0, 1);
    chk("bad_pat_no_offer", xfers.size() - n0, 0);
    scan_one(2, pat_tab[7], 3);
    idle(4);
    chk("recover_xfer_value", {16'd0, xfers[$]}, 32'h4728);

    // Multi-hot strobe: error next cycle, digits untouched.
    n0 = xfers.size();
    cyc(4'b0101, 7'($urandom), rdy_g);
    chk("multi_sel_error", {31'd0, bus.error}, 32'd1);
    scan_one(0, pat_tab[8], 2);
    idle(3);
    chk("multi_sel_no_offer", xfers.size() - n0, 0);

    // Back-pressure: offer held through digit updates, then next offer after one low cycle.
    do_reset("reset2");
    rdy_g = 1'b0;
    scan_all(1, 2, 3, 4, 3);
    idle(3);
    chk("hold_valid", {31'd0, bus.value_valid}, 32'd1);
    chk("hold_value", {16'd0, bus.value}, 32'h4321);
    scan_one(3, pat_tab[15], 3);
    idle(2);
    chk("held_valid", {31'd0, bus.value_valid}, 32'd1);
    chk("held_value", {16'd0, bus.value}, 32'h4321);
    n0 = xfers.size();
    cyc(4'd0, 7'd0, 1'b1);
    chk("xfer_taken", {16'd0, xfers[$]}, 32'h4321);
    chk("gap_valid_low", {31'd0, bus.value_valid}, 32'd0);
    cyc(4'd0, 7'd0, 1'b1);
    chk("next_valid", {31'd0, bus.value_valid}, 32'd1);
    chk("next_value", {16'd0, bus.value}, 32'hF321);
    rdy_g = 1'b1;
    idle(2);

    // Reset during an outstanding offer and a partial count.
    rdy_g = 1'b0;
    scan_one(0, pat_tab[8], 3);
    idle(2);
    chk("pre_reset_valid", {31'd0, bus.value_valid}, 32'd1);
    scan_one(1, pat_tab[6], 2);
    do_reset("mid_reset");
    scan_all(1, 2, 3, 4, 2);
    idle(3);
    chk("post_reset_no_offer", {31'd0, bus.value_valid}, 32'd0);
    scan_all(1, 2, 3, 4, 1);
    idle(2);
    chk("post_reset_valid", {31'd0, bus.value_valid}, 32'd1);
    chk("post_reset_value", {16'd0, bus.value}, 32'h4321);

    // Randomised scanning with random back-pressure against the model.
    for (int d = 0; d < 4; d++) tgt[d] = int'(pat_tab[$urandom_range(0, 15)]);
    for (int i = 0; i < 2000; i++) begin
      int r, d;
      r = $urandom_range(0, 99);
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 8) begin
        if ($urandom_range(0, 99) < 85) tgt[d] = int'(pat_tab[$urandom_range(0, 15)]);
        else tgt[d] = $urandom_range(0, 127);
      end
      if (r < 5) s = 4'd0;
      else if (r < 10) begin
        s = 4'($urandom_range(0, 15));
        if ($countones(s) < 2) s = 4'b1001;
      end else s = 4'(1 << d);
      cyc(s, 7'(tgt[d]), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
